// File: rtl/coeff_expand_if.sv
// Coefficient stream / expanded frame bus for coeff_expand.
// The slave modport is the block itself; the master modport is the source/sink around it.
interface coeff_expand_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 19
);
  // Serial coefficient input side
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_coef;
  logic                    in_last;

  // Frame output side
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] fraction_z0;
  logic signed [OUT_W-1:0] fraction_z1;
  logic signed [OUT_W-1:0] fraction_z2;
  logic signed [OUT_W-1:0] fraction_z3;
  logic signed [OUT_W-1:0] fraction_z4;
  logic signed [OUT_W-1:0] fraction_z5;
  logic signed [OUT_W-1:0] fraction_z6;
  logic signed [OUT_W-1:0] fraction_z7;
  logic                    out_short;
  logic [15:0]             frame_cnt;

  modport slave (
    input  in_valid, in_coef, in_last, out_ready,
    output in_ready, out_valid, out_short, frame_cnt,
    output fraction_z0, fraction_z1, fraction_z2, fraction_z3,
    output fraction_z4, fraction_z5, fraction_z6, fraction_z7
  );

  modport master (
    output in_valid, in_coef, in_last, out_ready,
    input  in_ready, out_valid, out_short, frame_cnt,
    input  fraction_z0, fraction_z1, fraction_z2, fraction_z3,
    input  fraction_z4, fraction_z5, fraction_z6, fraction_z7
  );
endinterface

// File: rtl/coeff_expand.sv
// Rebuilds 8-coefficient frames from a serial 12-bit integer stream, expanding each to Q11.7.
// Optional macro COEFF_EXPAND_HALF_LSB_EN: midpoint reconstruction (+0.5 LSB on written slots).
module coeff_expand #(
  parameter int N_COEF    = 8,   // output port list is fixed at 8 slots
  parameter int FRAC_BITS = 7,
  parameter int IN_W      = 12
) (
  input  logic           clk,
  input  logic           rst,
  coeff_expand_if.slave  bus
);

  localparam int OUT_W = IN_W + FRAC_BITS;
  localparam logic [2:0] LAST_IDX = 3'(N_COEF - 1);

`ifdef COEFF_EXPAND_HALF_LSB_EN
  // Midpoint of the truncated interval compensates the floor bias of the forward stage.
  localparam logic [FRAC_BITS-1:0] FRAC_FILL = {1'b1, {(FRAC_BITS-1){1'b0}}};
`else
  localparam logic [FRAC_BITS-1:0] FRAC_FILL = '0;
`endif

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              idx_q;
  logic signed [OUT_W-1:0] slot_q [N_COEF];
  logic                    short_q;
  logic [15:0]             frame_cnt_q;

  logic                    in_xfer;
  logic                    out_hs;
  logic                    frame_close;
  logic signed [OUT_W-1:0] expanded;

  assign in_xfer     = bus.in_valid && (state_q == COLLECT);
  assign out_hs      = bus.out_ready && (state_q == PRESENT);
  assign frame_close = in_xfer && (bus.in_last || (idx_q == LAST_IDX));
  assign expanded    = {bus.in_coef, FRAC_FILL};

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (frame_close) state_d = PRESENT;
      PRESENT: if (bus.out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // NOTE: the slot array is reset because it drives the output ports directly; zero-fill relies on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_COEF; k++) slot_q[k] <= '0;
      idx_q       <= '0;
      short_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else if (in_xfer) begin
      slot_q[idx_q] <= expanded;
      idx_q         <= idx_q + 3'd1;
      if (frame_close) short_q <= (idx_q != LAST_IDX);
    end else if (out_hs) begin
      // Clearing here leaves untouched slots at zero when the next frame ends early.
      for (int k = 0; k < N_COEF; k++) slot_q[k] <= '0;
      idx_q       <= '0;
      short_q     <= 1'b0;
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.in_ready    = (state_q == COLLECT);
  assign bus.out_valid   = (state_q == PRESENT);
  assign bus.out_short   = short_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.fraction_z0 = slot_q[0];
  assign bus.fraction_z1 = slot_q[1];
  assign bus.fraction_z2 = slot_q[2];
  assign bus.fraction_z3 = slot_q[3];
  assign bus.fraction_z4 = slot_q[4];
  assign bus.fraction_z5 = slot_q[5];
  assign bus.fraction_z6 = slot_q[6];
  assign bus.fraction_z7 = slot_q[7];

endmodule
